// File: rtl/pattern_predictor_scheduler_if.sv
// Bus between the requesting streams and the predictor/scheduler:
// request/outcome handshake, registered result and counter readback.
interface pattern_predictor_scheduler_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       req;
    logic [3:0]       act;
    logic [3:0]       gnt;
    logic             out_valid;
    logic [1:0]       out_id;
    logic             out_pred;
    logic             out_match;
    logic [1:0]       rd_sel;
    logic [CNT_W-1:0] rd_x_cnt;
    logic [CNT_W-1:0] rd_z_cnt;
    logic [1:0]       rd_state;

    modport master (
        output req, act, rd_sel,
        input  gnt, out_valid, out_id, out_pred, out_match,
        input  rd_x_cnt, rd_z_cnt, rd_state
    );

    modport slave (
        input  req, act, rd_sel,
        output gnt, out_valid, out_id, out_pred, out_match,
        output rd_x_cnt, rd_z_cnt, rd_state
    );
endinterface

// File: rtl/pattern_predictor_scheduler.sv
// Four 2-bit saturating outcome predictors sharing one compare/update path.
// A round-robin arbiter picks one requesting stream per cycle; the granted
// stream's prediction is checked against its actual outcome, its predictor
// and counters are updated, and the result is registered one cycle later.
module pattern_predictor_scheduler #(
    parameter int CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    pattern_predictor_scheduler_if.slave bus
);

    logic [1:0]       ptr_reg;
    logic             out_valid_reg;
    logic [1:0]       out_id_reg;
    logic             out_pred_reg;
    logic             out_match_reg;

    logic [3:0]       grant;
    logic             grant_any;
    logic [1:0]       grant_idx;
    logic [1:0]       cand;

    logic [1:0]       state_q [4];
    logic [CNT_W-1:0] x_cnt_q [4];
    logic [CNT_W-1:0] z_cnt_q [4];
    logic [3:0]       hit_vec;

    // Round-robin search from ptr; scanning offsets high-to-low lets the
    // lowest offset from ptr overwrite and win. Reset or clear blocks all grants.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 2'd0;
        cand      = 2'd0;
        if (rst && !clr) begin
            for (int k = 3; k >= 0; k--) begin
                cand = ptr_reg + 2'(k);
                if (bus.req[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    assign grant   = grant_any ? (4'b0001 << grant_idx) : 4'b0000;
    assign bus.gnt = grant;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_stream
            logic [1:0]       state_reg;
            logic [CNT_W-1:0] x_cnt_reg;
            logic [CNT_W-1:0] z_cnt_reg;

            // Prediction is the state's MSB; a hit means it matches the outcome.
            assign hit_vec[gi] = (state_reg[1] == bus.act[gi]);

            // Saturating predictor and counter update when this stream is granted.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_reg <= 2'b00;
                    x_cnt_reg <= '0;
                    z_cnt_reg <= '0;
                end else if (clr) begin
                    state_reg <= 2'b00;
                    x_cnt_reg <= '0;
                    z_cnt_reg <= '0;
                end else if (grant[gi]) begin
                    if (bus.act[gi]) begin
                        if (state_reg != 2'b11) state_reg <= state_reg + 2'd1;
                    end else begin
                        if (state_reg != 2'b00) state_reg <= state_reg - 2'd1;
                    end
                    if (x_cnt_reg != '1) x_cnt_reg <= x_cnt_reg + 1'b1;
                    if (hit_vec[gi] && (z_cnt_reg != '1)) z_cnt_reg <= z_cnt_reg + 1'b1;
                end
            end

            assign state_q[gi] = state_reg;
            assign x_cnt_q[gi] = x_cnt_reg;
            assign z_cnt_q[gi] = z_cnt_reg;
        end
    endgenerate

    // Pointer advance and registered result; id/pred/match hold when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg       <= 2'd0;
            out_valid_reg <= 1'b0;
            out_id_reg    <= 2'd0;
            out_pred_reg  <= 1'b0;
            out_match_reg <= 1'b0;
        end else if (clr) begin
            ptr_reg       <= 2'd0;
            out_valid_reg <= 1'b0;
        end else if (grant_any) begin
            ptr_reg       <= grant_idx + 2'd1;
            out_valid_reg <= 1'b1;
            out_id_reg    <= grant_idx;
            out_pred_reg  <= state_q[grant_idx][1];
            out_match_reg <= hit_vec[grant_idx];
        end else begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_id    = out_id_reg;
    assign bus.out_pred  = out_pred_reg;
    assign bus.out_match = out_match_reg;

    assign bus.rd_x_cnt  = x_cnt_q[bus.rd_sel];
    assign bus.rd_z_cnt  = z_cnt_q[bus.rd_sel];
    assign bus.rd_state  = state_q[bus.rd_sel];

endmodule

// File: tb/tb_pattern_predictor_scheduler.sv
// Bench for pattern_predictor_scheduler: a behavioural model checked on
// every falling clock edge, plus directed scenarios with literal expectations.
module tb_pattern_predictor_scheduler;
    localparam int CNT_W = 8;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;

    pattern_predictor_scheduler_if #(.CNT_W(CNT_W)) bus ();

    pattern_predictor_scheduler #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: plain integers, predict "1" when the counter is in
    // its upper half, counters clamp at MAXC.
    int   m_state [4];
    int   m_x [4];
    int   m_z [4];
    int   m_ptr;
    logic m_ov;
    int   m_id;
    logic m_pred;
    logic m_match;

    function automatic int winner();
        if (!rst || clr) return -1;
        for (int k = 0; k < 4; k++) begin
            if (bus.req[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_gnt();
        int w;
        w = winner();
        if (w < 0) return 4'b0000;
        return 4'(1 << w);
    endfunction

    task automatic model_zero(input bit full);
        for (int i = 0; i < 4; i++) begin
            m_state[i] = 0;
            m_x[i] = 0;
            m_z[i] = 0;
        end
        m_ptr = 0;
        m_ov  = 1'b0;
        if (full) begin
            m_id = 0;
            m_pred = 1'b0;
            m_match = 1'b0;
        end
    endtask

    // Model update at each rising edge, or immediately on reset assertion.
    always @(posedge clk or negedge rst) begin : model_step
        int w;
        if (!rst) begin
            model_zero(1'b1);
        end else if (clr) begin
            model_zero(1'b0);
        end else begin
            w = winner();
            if (w >= 0) begin
                m_pred  = (m_state[w] >= 2);
                m_match = (m_pred == bus.act[w]);
                if (bus.act[w]) m_state[w] = (m_state[w] == 3) ? 3 : m_state[w] + 1;
                else            m_state[w] = (m_state[w] == 0) ? 0 : m_state[w] - 1;
                if (m_x[w] < MAXC) m_x[w]++;
                if (m_match && m_z[w] < MAXC) m_z[w]++;
                m_ptr = (w + 1) % 4;
                m_ov  = 1'b1;
                m_id  = w;
            end else begin
                m_ov = 1'b0;
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        check("gnt", 32'(bus.gnt), 32'(exp_gnt()));
        check("out_valid", 32'(bus.out_valid), 32'(m_ov));
        check("out_id", 32'(bus.out_id), 32'(m_id));
        check("out_pred", 32'(bus.out_pred), 32'(m_pred));
        check("out_match", 32'(bus.out_match), 32'(m_match));
        check("rd_x_cnt", 32'(bus.rd_x_cnt), 32'(m_x[bus.rd_sel]));
        check("rd_z_cnt", 32'(bus.rd_z_cnt), 32'(m_z[bus.rd_sel]));
        check("rd_state", 32'(bus.rd_state), 32'(m_state[bus.rd_sel]));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulse();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Stream 0 alone with outcomes 0,0,1,1,1,1 from a fresh state.
    task automatic run_seq0(input string tag);
        bit seq [6];
        bit ep [6];
        bit em [6];
        seq = '{0, 0, 1, 1, 1, 1};
        ep  = '{0, 0, 0, 0, 1, 1};
        em  = '{1, 1, 0, 0, 1, 1};
        for (int i = 0; i < 6; i++) begin
            bus.req = 4'b0001;
            bus.act = {3'b000, seq[i]};
            tick();
            check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_pred"}, 32'(bus.out_pred), 32'(ep[i]));
            check({tag, "_match"}, 32'(bus.out_match), 32'(em[i]));
        end
        bus.req = 4'b0000;
        bus.rd_sel = 2'd0;
        #1;
        check({tag, "_x"}, 32'(bus.rd_x_cnt), 32'd6);
        check({tag, "_z"}, 32'(bus.rd_z_cnt), 32'd4);
        check({tag, "_state"}, 32'(bus.rd_state), 32'd3);
    endtask

    initial begin : stimulus
        logic [3:0] rr_gnt [6];
        bus.req = 4'b1111;
        bus.act = 4'b0000;
        bus.rd_sel = 2'd0;

        // Reset asserted: grants blocked even with all streams requesting.
        #1 rst = 1'b0;
        #3;
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_x", 32'(bus.rd_x_cnt), 32'd0);
        #8 rst = 1'b1;
        bus.req = 4'b0000;

        run_seq0("seq0");

        // Asynchronous reset between edges mid-stream, then restart.
        bus.req = 4'b0001;
        bus.act = 4'b0001;
        tick();
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst_x", 32'(bus.rd_x_cnt), 32'd0);
        check("arst_state", 32'(bus.rd_state), 32'd0);
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_gnt", 32'(bus.gnt), 32'd0);
        #2 rst = 1'b1;
        run_seq0("restart");

        // All streams requesting straight out of reset.
        #1 rst = 1'b0;
        #1 rst = 1'b1;
        rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        bus.req = 4'b1111;
        bus.act = 4'b0000;
        #1;
        check("rr_gnt0", 32'(bus.gnt), 32'(rr_gnt[0]));
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_out_id", 32'(bus.out_id), 32'(i % 4));
            check("rr_gnt", 32'(bus.gnt), 32'(rr_gnt[i + 1]));
        end
        bus.req = 4'b0000;

        // Streams 1 and 3 only, pointer at 0.
        clear_pulse();
        bus.req = 4'b1010;
        #1;
        check("alt_gnt0", 32'(bus.gnt), 32'b0010);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("alt_gnt", 32'(bus.gnt), (i % 2 == 0) ? 32'b1000 : 32'b0010);
        end
        bus.req = 4'b0000;
        bus.rd_sel = 2'd0;
        #1;
        check("alt_x0", 32'(bus.rd_x_cnt), 32'd0);
        bus.rd_sel = 2'd2;
        #1;
        check("alt_x2", 32'(bus.rd_x_cnt), 32'd0);
        check("alt_z2", 32'(bus.rd_z_cnt), 32'd0);

        // Counter saturation on stream 1.
        clear_pulse();
        bus.req = 4'b0010;
        bus.act = 4'b0000;
        repeat (260) @(posedge clk);
        #1;
        bus.req = 4'b0000;
        bus.rd_sel = 2'd1;
        #1;
        check("sat_x", 32'(bus.rd_x_cnt), 32'd255);
        check("sat_z", 32'(bus.rd_z_cnt), 32'd255);
        check("sat_state", 32'(bus.rd_state), 32'd0);

        // Clear colliding with a request.
        clear_pulse();
        bus.req = 4'b0001;
        bus.act = 4'b0001;
        repeat (3) tick();
        clr = 1'b1;
        #1;
        check("clr_gnt", 32'(bus.gnt), 32'd0);
        tick();
        check("clr_valid", 32'(bus.out_valid), 32'd0);
        bus.rd_sel = 2'd0;
        #1;
        check("clr_x", 32'(bus.rd_x_cnt), 32'd0);
        check("clr_state", 32'(bus.rd_state), 32'd0);
        clr = 1'b0;
        #1;
        check("clr_next_gnt", 32'(bus.gnt), 32'b0001);
        tick();
        check("clr_next_valid", 32'(bus.out_valid), 32'd1);
        check("clr_next_id", 32'(bus.out_id), 32'd0);
        check("clr_next_x", 32'(bus.rd_x_cnt), 32'd1);
        bus.req = 4'b0000;

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
